// File: rtl/l2_mem_responder.sv
// l2_mem_responder: memory-side responder for the L2 arbiter request interface.
// Serves arbitrated read, write and atomic-swap requests from an internal
// synchronous word-addressed RAM. Read data returns in order through a single
// output register, tagged with the full L2 id.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   request_*           arbitrated request (valid/pop handshake)
//   wr_data_*           write-data stream (valid/pop handshake, byte enables)
//   rd_data_valid/ready return data handshake; rd_data, rd_id held while stalled
module l2_mem_responder #(
    parameter int unsigned L2_ID_W    = 3,
    parameter int unsigned MEM_ADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               request_valid,
    output logic               request_pop,
    input  logic [29:0]        request_addr,
    input  logic               request_rnw,
    input  logic               request_is_amo,
    input  logic [4:0]         request_burst_size,
    input  logic [L2_ID_W-1:0] request_id,
    input  logic               wr_data_valid,
    output logic               wr_data_pop,
    input  logic [31:0]        wr_data,
    input  logic [3:0]         wr_data_be,
    output logic               rd_data_valid,
    input  logic               rd_data_ready,
    output logic [31:0]        rd_data,
    output logic [L2_ID_W-1:0] rd_id
);

    localparam int unsigned DEPTH   = 1 << MEM_ADDR_W;
    localparam int unsigned BEAT_W  = 5;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BYTES   = WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        AMO   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [MEM_ADDR_W-1:0] base_addr;
    logic [BEAT_W-1:0]     burst_size;
    logic [BEAT_W-1:0]     beat;
    logic [L2_ID_W-1:0]    id_q;
    logic [MEM_ADDR_W-1:0] mem_idx;
    logic                  out_free;
    logic                  rd_issue;
    logic                  mem_we;
    logic                  beat_adv;

    logic [WORD_W-1:0] mem [DEPTH];

    // Upper request address bits fall outside the RAM and are ignored.
    logic unused_addr;
    assign unused_addr = ^request_addr[29:MEM_ADDR_W];

    // Linear address increment, wrapping naturally at the top of the RAM.
    assign mem_idx  = base_addr + MEM_ADDR_W'(beat);
    assign out_free = !rd_data_valid || rd_data_ready;

    // Next-state and handshake decode.
    always_comb begin
        state_next  = state;
        request_pop = 1'b0;
        wr_data_pop = 1'b0;
        rd_issue    = 1'b0;
        mem_we      = 1'b0;
        beat_adv    = 1'b0;
        unique case (state)
            IDLE: begin
                request_pop = request_valid;
                if (request_valid) begin
                    if (request_is_amo)   state_next = AMO;
                    else if (request_rnw) state_next = READ;
                    else                  state_next = WRITE;
                end
            end
            READ: begin
                if (out_free) begin
                    rd_issue = 1'b1;
                    beat_adv = 1'b1;
                    if (beat == burst_size) state_next = IDLE;
                end
            end
            WRITE: begin
                if (wr_data_valid) begin
                    wr_data_pop = 1'b1;
                    mem_we      = 1'b1;
                    beat_adv    = 1'b1;
                    if (beat == burst_size) state_next = IDLE;
                end
            end
            AMO: begin
                // Swap: read-first access returns the old word while writing the new one.
                if (wr_data_valid && out_free) begin
                    wr_data_pop = 1'b1;
                    mem_we      = 1'b1;
                    rd_issue    = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // No handshakes or RAM side effects while held in reset.
        if (rst) begin
            request_pop = 1'b0;
            wr_data_pop = 1'b0;
            rd_issue    = 1'b0;
            mem_we      = 1'b0;
            beat_adv    = 1'b0;
            state_next  = IDLE;
        end
    end

    // State, request latch and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= '0;
            base_addr  <= '0;
            burst_size <= '0;
            id_q       <= '0;
        end else begin
            state <= state_next;
            if (request_pop) begin
                base_addr  <= request_addr[MEM_ADDR_W-1:0];
                burst_size <= request_burst_size;
                id_q       <= request_id;
                beat       <= '0;
            end else if (beat_adv) begin
                beat <= beat + BEAT_W'(1);
            end
        end
    end

    // Return register: loads on issue, otherwise drains when accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
            rd_id         <= '0;
        end else if (rd_issue) begin
            rd_data_valid <= 1'b1;
            rd_data       <= mem[mem_idx];
            rd_id         <= id_q;
        end else if (rd_data_ready) begin
            rd_data_valid <= 1'b0;
        end
    end

    // Byte-enabled RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_data_be[b]) mem[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Scoreboard bench for l2_mem_responder: a word model of the RAM produces the
// expected return beats, which a monitor compares as the DUT hands them over.
module tb_l2_mem_responder;

    localparam int unsigned L2_ID_W    = 3;
    localparam int unsigned MEM_ADDR_W = 12;
    localparam int unsigned DEPTH      = 1 << MEM_ADDR_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               request_valid;
    logic               request_pop;
    logic [29:0]        request_addr;
    logic               request_rnw;
    logic               request_is_amo;
    logic [4:0]         request_burst_size;
    logic [L2_ID_W-1:0] request_id;
    logic               wr_data_valid;
    logic               wr_data_pop;
    logic [31:0]        wr_data;
    logic [3:0]         wr_data_be;
    logic               rd_data_valid;
    logic               rd_data_ready;
    logic [31:0]        rd_data;
    logic [L2_ID_W-1:0] rd_id;

    l2_mem_responder #(.L2_ID_W(L2_ID_W), .MEM_ADDR_W(MEM_ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .request_valid(request_valid), .request_pop(request_pop),
        .request_addr(request_addr), .request_rnw(request_rnw),
        .request_is_amo(request_is_amo), .request_burst_size(request_burst_size),
        .request_id(request_id),
        .wr_data_valid(wr_data_valid), .wr_data_pop(wr_data_pop),
        .wr_data(wr_data), .wr_data_be(wr_data_be),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
        .rd_data(rd_data), .rd_id(rd_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_cyc = 0;
    int rx_count = 0;
    bit lat_arm = 0;
    bit bp_en = 0;
    logic [3:0] ready_pat = 4'b1001;

    logic [31:0] model [DEPTH];
    logic [34:0] exp_q [$];      // {id, data}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ready driver: always ready, or the 1,0,0,1 backpressure pattern.
    initial begin
        int rp = 0;
        rd_data_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_en) begin
                rd_data_ready = ready_pat[rp];
                rp = (rp + 1) % 4;
            end else begin
                rd_data_ready = 1'b1;
            end
        end
    end

    // Monitor: compares accepted beats against the scoreboard, checks stall stability.
    initial begin
        bit          held = 0;
        logic [31:0] hold_d;
        logic [2:0]  hold_i;
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
            end else begin
                if (held) begin
                    check("hold_valid", 32'(rd_data_valid), 32'd1);
                    check("hold_data", rd_data, hold_d);
                    check("hold_id", 32'(rd_id), 32'(hold_i));
                end
                if (lat_arm && rd_data_valid) begin
                    check("latency", 32'(cyc - pop_cyc), 32'd2);
                    lat_arm = 0;
                end
                if (rd_data_valid && rd_data_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'(rd_data_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_data", rd_data, e[31:0]);
                        check("rd_id", 32'(rd_id), 32'(e[34:32]));
                    end
                    rx_count++;
                end
                held   = rd_data_valid && !rd_data_ready;
                hold_d = rd_data;
                hold_i = rd_id;
            end
        end
    end

    function automatic logic [MEM_ADDR_W-1:0] idx(input logic [29:0] a, input int beat);
        return MEM_ADDR_W'(a[MEM_ADDR_W-1:0] + MEM_ADDR_W'(beat));
    endfunction

    task automatic send_req(input logic [29:0] a, input logic rnw, input logic amo,
                            input logic [4:0] bs, input logic [2:0] id);
        int n = 0;
        @(posedge clk); #1;
        request_valid      = 1'b1;
        request_addr       = a;
        request_rnw        = rnw;
        request_is_amo     = amo;
        request_burst_size = bs;
        request_id         = id;
        @(negedge clk);
        while (!request_pop && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!request_pop) check("req_timeout", 32'(request_pop), 32'd1);
        else pop_cyc = cyc;
        @(posedge clk); #1;
        request_valid = 1'b0;
    endtask

    // Presents one word and returns once it is being popped (valid left high).
    task automatic put_wdata(input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        @(posedge clk); #1;
        wr_data_valid = 1'b1;
        wr_data       = d;
        wr_data_be    = be;
        @(negedge clk);
        while (!wr_data_pop && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!wr_data_pop) check("wdata_timeout", 32'(wr_data_pop), 32'd1);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic write_burst(input logic [29:0] a, input logic [31:0] w[$],
                               input logic [3:0] be, input bit gaps);
        send_req(a, 1'b0, 1'b0, 5'(w.size() - 1), 3'd0);
        foreach (w[i]) begin
            put_wdata(w[i], be);
            model[idx(a, i)] = merge(model[idx(a, i)], w[i], be);
            if (gaps && (i % 2 == 1)) begin
                @(posedge clk); #1;
                wr_data_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        wr_data_valid = 1'b0;
    endtask

    task automatic read_burst(input logic [29:0] a, input logic [4:0] bs, input logic [2:0] id);
        for (int i = 0; i <= int'(bs); i++) exp_q.push_back({id, model[idx(a, i)]});
        send_req(a, 1'b1, 1'b0, bs, id);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w [$];
        int n;
        rst = 1'b1;
        request_valid = 1'b1;
        request_addr = '0;
        request_rnw = 1'b1;
        request_is_amo = 1'b0;
        request_burst_size = '0;
        request_id = '0;
        wr_data_valid = 1'b1;
        wr_data = '0;
        wr_data_be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_valid", 32'(rd_data_valid), 32'd0);
        check("rst_rd_id", 32'(rd_id), 32'd0);
        check("rst_req_pop", 32'(request_pop), 32'd0);
        check("rst_wd_pop", 32'(wr_data_pop), 32'd0);
        request_valid = 1'b0;
        wr_data_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single write, then read with latency measurement.
        w = '{32'hDEADBEEF};
        write_burst(30'h10, w, 4'hF, 0);
        check("no_stray_wd_pop", 32'(wr_data_pop), 32'd0);
        lat_arm = 1;
        read_burst(30'h10, 5'd0, 3'd5);
        wait_drain();
        check("latency_seen", 32'(lat_arm), 32'd0);

        // Upper address bits ignored.
        read_burst(30'h2000_0010, 5'd0, 3'd1);
        wait_drain();

        // Byte enables.
        w = '{32'h11223344};
        write_burst(30'h3, w, 4'hF, 0);
        w = '{32'hAABBCCDD};
        write_burst(30'h3, w, 4'h5, 0);
        read_burst(30'h3, 5'd0, 3'd7);
        wait_drain();

        // Burst with write bubbles, read with backpressure.
        w = '{};
        for (int i = 0; i < 8; i++) w.push_back(32'(i));
        write_burst(30'h20, w, 4'hF, 1);
        bp_en = 1;
        read_burst(30'h20, 5'd7, 3'd3);
        wait_drain();
        bp_en = 0;

        // Wrap at the top of the RAM.
        w = '{32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004};
        write_burst(30'hFFE, w, 4'hF, 0);
        read_burst(30'hFFE, 5'd3, 3'd4);
        wait_drain();
        read_burst(30'h0, 5'd1, 3'd6);
        wait_drain();

        // AMO swap, rnw also set to show is_amo wins; burst field carries amo_type.
        w = '{32'h5};
        write_burst(30'h7, w, 4'hF, 0);
        exp_q.push_back({3'd2, model[7]});
        send_req(30'h7, 1'b1, 1'b1, 5'd9, 3'd2);
        put_wdata(32'h9, 4'hF);
        model[7] = 32'h9;
        @(posedge clk); #1;
        wr_data_valid = 1'b0;
        wait_drain();
        read_burst(30'h7, 5'd0, 3'd4);
        wait_drain();

        // Reset in the middle of a 16-beat read.
        w = '{};
        for (int i = 0; i < 16; i++) w.push_back(32'hC0DE_0000 + 32'(i));
        write_burst(30'h100, w, 4'hF, 0);
        rx_count = 0;
        read_burst(30'h100, 5'd15, 3'd6);
        n = 0;
        while (rx_count < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_reached", 32'(rx_count >= 3), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("mid_rst_rd_valid", 32'(rd_data_valid), 32'd0);
        check("mid_rst_rd_id", 32'(rd_id), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle_valid", 32'(rd_data_valid), 32'd0);
        read_burst(30'h10, 5'd0, 3'd5);
        wait_drain();
        read_burst(30'h20, 5'd3, 3'd2);
        wait_drain();
        read_burst(30'h100, 5'd2, 3'd1);
        wait_drain();

        check("leftover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_mem_responder.md
Name: l2_mem_responder

Overview:
- Memory-side responder for the L2 arbiter's memory request interface.
- Consumes arbitrated requests (address, rnw, is_amo, burst size, L2 id) and the matching write-data stream.
- Serves requests from an internal synchronous word-addressed RAM and returns read data tagged with the full L2 id.
- Used as the on-chip backing memory in FPGA builds and as the memory model in arbiter testbenches.

Parameters:
- L2_ID_W, 3, width of the request/return id (port id bits + sub_id bits; upper $clog2(L2_NUM_PORTS) bits are the port id).
- MEM_ADDR_W, 12, RAM word-address width; depth is 2**MEM_ADDR_W 32-bit words.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- request_valid  in  1  request available at arbiter output
- request_pop  out  1  request accepted this cycle
- request_addr  in  30  word address
- request_rnw  in  1  1 = read, 0 = write
- request_is_amo  in  1  atomic (swap) request
- request_burst_size  in  5  beats minus one (0..31 -> 1..32 words)
- request_id  in  L2_ID_W  requester id
- wr_data_valid  in  1  write data word available
- wr_data_pop  out  1  write data word consumed this cycle
- wr_data  in  32  write data word
- wr_data_be  in  4  byte enables for wr_data
- rd_data_valid  out  1  return data valid
- rd_data_ready  in  1  arbiter accepts return data
- rd_data  out  32  return data
- rd_id  out  L2_ID_W  id of returning request

Behaviour:
- Reset: state IDLE, request_pop = 0, wr_data_pop = 0, rd_data_valid = 0, rd_id = 0, beat counter = 0. RAM contents are not cleared.
- Reset mid-burst: abandons the burst and returns to IDLE. Writes already performed persist. The in-flight return beat is dropped.
- Addressing: RAM index = (request_addr[MEM_ADDR_W-1:0] + beat) mod 2**MEM_ADDR_W. Linear increment, wraps at top of RAM. Upper address bits are ignored.
- Output advance: out_free = !rd_data_valid || rd_data_ready. While rd_data_valid = 1 and rd_data_ready = 0, rd_data and rd_id hold stable.
- FSM states: IDLE, READ, WRITE, AMO.
- IDLE:
  - request_pop = request_valid (combinational, only in IDLE).
  - On pop: latch addr, burst_size, id; clear beat counter.
  - Next state: is_amo -> AMO; else rnw -> READ; else WRITE.
  - Is_amo takes precedence over rnw.
- READ:
  - Each cycle out_free = 1: issue RAM read of current index and increment beat.
  - Data appears on rd_data with rd_data_valid = 1 and rd_id = latched id the next cycle.
  - After the issue with beat == burst_size -> IDLE.
  - Throughput 1 word/cycle with no backpressure.
  - Latency: request_pop at cycle T -> first rd_data_valid at T+2.
- WRITE:
  - Each cycle wr_data_valid = 1: wr_data_pop = 1; write wr_data into current index with per-byte enables wr_data_be; increment beat.
  - Bubbles on wr_data_valid = 0 are allowed.
  - After the write with beat == burst_size -> IDLE.
  - No return data for writes.
- AMO:
  - Single word only; burst_size is ignored (carries amo_type upstream) and treated as swap.
  - When wr_data_valid && out_free:
    - wr_data_pop = 1.
    - Same-cycle read-first RAM access returns the old word and writes wr_data with wr_data_be.
    - Old word on rd_data with rd_data_valid the next cycle.
    - -> IDLE.
- New requests are accepted only in IDLE; the earliest is one cycle after the last beat issue.
- A pending returned beat may still be draining while IDLE accepts the next request; rd ordering is preserved (single output register, in-order issue).
- wr_data_pop is never asserted outside WRITE/AMO. request_pop is never asserted outside IDLE.
- Beat counter is 5 bits; no overflow, since it terminates at burst_size ≤ 31.

Test Plan:
- Single write then read: write addr 0x10, burst 0, data 0xDEADBEEF, be 0xF; then read addr 0x10, id 5 -> rd_data = 0xDEADBEEF, rd_id = 5, first valid exactly 2 cycles after request_pop.
- Byte enables: preload 0x11223344 at addr 3; write 0xAABBCCDD with be 0x5 -> read returns 0x11BB33DD.
- Burst with backpressure: write 8 words 0..7 at addr 0x20 (burst 7); read burst 7, rd_data_ready toggling 1,0,0,1 -> exactly 8 beats 0..7 in order, data/id stable while stalled, no dropped or duplicated beats.
- Wrap-around: MEM_ADDR_W = 12, 4-beat write/read at addr 0xFFE -> words land at indexes 0xFFE, 0xFFF, 0x000, 0x001 and read back in that order.
- AMO swap: addr 7 holds 0x5; AMO id 2 with wr_data 0x9 -> rd_data = 0x5, rd_id = 2; subsequent read of addr 7 -> 0x9.
- Reset mid-read-burst: assert rst after 3 of 16 beats returned -> next cycle rd_data_valid = 0, state IDLE; a new read request is served normally and earlier written RAM data is intact.
